enc_pack_scheduler: RTL and testbench

Sequences the sparse-HDC encoder's binder packs. Each pack holds 10 binders with fixed shifts. On a start pulse, the block walks pack indices 0..NUM_PACKS-1. For each pack it:
- requests the pack's level hypervectors from the feature fetch unit,
- fires that pack's start_encoding,
- waits out the binder latency,
- hands the bound result to the downstream bundler/accumulator with a valid/ready handshake.

It sits between the top-level encoder FSM, the feature/level-HV fetch unit, the binder packs and the bundler.

---
 rtl/enc_pack_scheduler.sv | 100 ++++++++++
 tb/tb_enc_pack_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_pack_scheduler.sv
// Binder-pack sequencer for the sparse-HDC encoder: fetch -> bind -> wait -> emit per pack.
// Optional ENC_SCHED_PERF_CNT_EN adds a saturating stall counter output (stall_cnt).
module enc_pack_scheduler #(
  parameter int NUM_PACKS = 62,
  parameter int BIND_LAT  = 1,
  parameter int PIDX_W    = $clog2(NUM_PACKS)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 feat_req,
  output logic [PIDX_W-1:0]    feat_addr,
  input  logic                 feat_valid,
  output logic [NUM_PACKS-1:0] pack_start,
  output logic                 acc_clear,
  output logic                 out_valid,
  output logic [PIDX_W-1:0]    out_pack,
  output logic                 out_last,
  input  logic                 out_ready
`ifdef ENC_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int CNT_W = (BIND_LAT < 1) ? 1 : $clog2(BIND_LAT + 1);
  localparam logic [PIDX_W-1:0] LAST_P = PIDX_W'(NUM_PACKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_BIND, S_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t            state;
  logic [PIDX_W-1:0] p;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      p     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_CLEAR;
        S_CLEAR: begin
          p     <= '0;
          state <= S_FETCH;
        end
        S_FETCH: if (feat_valid) state <= S_BIND;
        S_BIND: begin
          cnt   <= CNT_W'(BIND_LAT);
          state <= (BIND_LAT == 0) ? S_EMIT : S_WAIT;
        end
        // WAIT occupies exactly BIND_LAT cycles: leave on the cycle the counter shows 1
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (p == LAST_P) begin
              state <= S_DONE;
            end else begin
              p     <= p + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode only; indices are gated so idle outputs read as zero
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign acc_clear  = (state == S_CLEAR);
  assign feat_req   = (state == S_FETCH);
  assign feat_addr  = feat_req ? p : '0;
  assign pack_start = (state == S_BIND) ? (NUM_PACKS'(1) << p) : '0;
  assign out_valid  = (state == S_EMIT);
  assign out_pack   = out_valid ? p : '0;
  assign out_last   = out_valid && (p == LAST_P);

`ifdef ENC_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (state == S_CLEAR) begin
      stall_cnt <= '0;
    end else if (((state == S_FETCH) && !feat_valid) || ((state == S_EMIT) && !out_ready)) begin
      if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// Self-checking bench: three schedulers (BIND_LAT 1, 0, 3) against a timeline model of a sample.
module tb_enc_pack_scheduler;
  localparam int N    = 4;
  localparam int MAXC = 160;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic feat_valid = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  // {busy, done, feat_req, feat_addr[1:0], pack_start[3:0], acc_clear, out_valid, out_pack[1:0], out_last}
  logic [13:0] obs [3];
`ifdef ENC_SCHED_PERF_CNT_EN
  logic [31:0] sobs [3];
  logic [31:0] sexp [3][MAXC];
`endif

  bit          start_tab [MAXC];
  bit          fv_tab    [MAXC];
  bit          or_tab    [MAXC];
  logic [13:0] exp_tab   [3][MAXC];
  logic [31:0] sc_state  [3];
  int          first_done [3];
  int          done_cnt   [3];
  int          clr_cnt    [3];
  int          tests = 0;
  int          fails = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    logic       busy, done, feat_req, acc_clear, out_valid, out_last;
    logic [1:0] feat_addr, out_pack;
    logic [3:0] pack_start;
`ifdef ENC_SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif
    enc_pack_scheduler #(.NUM_PACKS(N), .BIND_LAT(L), .PIDX_W(2)) u_dut (
      .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done),
      .feat_req(feat_req), .feat_addr(feat_addr), .feat_valid(feat_valid),
      .pack_start(pack_start), .acc_clear(acc_clear), .out_valid(out_valid),
      .out_pack(out_pack), .out_last(out_last), .out_ready(out_ready)
`ifdef ENC_SCHED_PERF_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
    );
    assign obs[k] = {busy, done, feat_req, feat_addr, pack_start, acc_clear,
                     out_valid, out_pack, out_last};
`ifdef ENC_SCHED_PERF_CNT_EN
    assign sobs[k] = stall_cnt;
`endif
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic logic [13:0] vec(input bit dn, input bit req, input bit clr,
                                      input bit ov, input bit ps_on, input int p);
    logic [1:0] pp;
    logic [3:0] ps;
    pp = p[1:0];
    ps = ps_on ? (4'b0001 << pp) : 4'b0000;
    return {1'b1, dn, req, (req ? pp : 2'b00), ps, clr, ov, (ov ? pp : 2'b00),
            (ov && (p == N - 1))};
  endfunction

  function automatic void put(input int k, input int c, input logic [13:0] v,
                              input logic [31:0] s);
    if (c < MAXC) begin
      exp_tab[k][c] = v;
`ifdef ENC_SCHED_PERF_CNT_EN
      sexp[k][c] = s;
`endif
    end
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] s);
    return (s == 32'hFFFF_FFFF) ? s : s + 32'd1;
  endfunction

  // Walks a sample as a timeline: clear, then per pack fetch/bind/wait/emit, then done.
  function automatic void build(input int k, input int lat, input int len);
    int c;
    logic [31:0] sc;
    c  = 0;
    sc = sc_state[k];
    while (c < len) begin
      put(k, c, 14'd0, sc);
      if (!start_tab[c]) begin
        c++;
      end else begin
        c++;
        put(k, c, vec(0, 0, 1, 0, 0, 0), sc);
        sc = 0;
        c++;
        for (int p = 0; p < N; p++) begin
          while (c < len && !fv_tab[c]) begin
            put(k, c, vec(0, 1, 0, 0, 0, p), sc);
            sc = sat_inc(sc);
            c++;
          end
          put(k, c, vec(0, 1, 0, 0, 0, p), sc);
          c++;
          put(k, c, vec(0, 0, 0, 0, 1, p), sc);
          c++;
          for (int w = 0; w < lat; w++) begin
            put(k, c, vec(0, 0, 0, 0, 0, 0), sc);
            c++;
          end
          while (c < len && !or_tab[c]) begin
            put(k, c, vec(0, 0, 0, 1, 0, p), sc);
            sc = sat_inc(sc);
            c++;
          end
          put(k, c, vec(0, 0, 0, 1, 0, p), sc);
          c++;
        end
        put(k, c, vec(1, 0, 0, 0, 0, 0), sc);
        c++;
      end
    end
    sc_state[k] = sc;
  endfunction

  task automatic fill_ideal();
    for (int c = 0; c < MAXC; c++) begin
      start_tab[c] = 1'b0;
      fv_tab[c]    = 1'b1;
      or_tab[c]    = 1'b1;
    end
  endtask

  // Starts at posedge+1 of cycle 0 and returns at posedge+1 of cycle len.
  task automatic run(input int len);
    for (int k = 0; k < 3; k++) begin
      build(k, lat_of(k), len);
      first_done[k] = -1;
      done_cnt[k]   = 0;
      clr_cnt[k]    = 0;
    end
    for (int c = 0; c < len; c++) begin
      start      = start_tab[c];
      feat_valid = fv_tab[c];
      out_ready  = or_tab[c];
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs[k] !== exp_tab[k][c]) begin
          fails++;
          $display("FAIL outputs lat=%0d cyc=%0d got %h expected %h", lat_of(k), c,
                   obs[k], exp_tab[k][c]);
        end
`ifdef ENC_SCHED_PERF_CNT_EN
        tests++;
        if (sobs[k] !== sexp[k][c]) begin
          fails++;
          $display("FAIL stall_cnt lat=%0d cyc=%0d got %0d expected %0d", lat_of(k), c,
                   sobs[k], sexp[k][c]);
        end
`endif
        if (obs[k][12]) begin
          done_cnt[k]++;
          if (first_done[k] < 0) first_done[k] = c;
        end
        if (obs[k][4]) clr_cnt[k]++;
      end
      @(posedge clk);
      #1;
    end
    start      = 1'b0;
    feat_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic check_done(input string name, input int k, input int want);
    tests++;
    if (first_done[k] !== want) begin
      fails++;
      $display("FAIL %s lat=%0d done at cycle %0d expected %0d", name, lat_of(k),
               first_done[k], want);
    end
  endtask

  task automatic release_reset();
    for (int k = 0; k < 3; k++) sc_state[k] = 32'd0;
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs[k] !== 14'd0) begin
        fails++;
        $display("FAIL reset_outputs lat=%0d got %h expected 0", lat_of(k), obs[k]);
      end
    end
    release_reset();
  endtask

  task automatic test_nominal();
    fill_ideal();
    start_tab[0] = 1'b1;
    run(34);
    for (int k = 0; k < 3; k++) check_done("nominal_done", k, 2 + N * (3 + lat_of(k)));
  endtask

  task automatic test_backpressure();
    fill_ideal();
    start_tab[0] = 1'b1;
    for (int c = 13; c < 18; c++) or_tab[c] = 1'b0;
    run(40);
    check_done("backpressure_done", 0, 18 + 5);
`ifdef ENC_SCHED_PERF_CNT_EN
    tests++;
    if (sobs[0] !== 32'd5) begin
      fails++;
      $display("FAIL backpressure_stall_cnt got %0d expected 5", sobs[0]);
    end
`endif
  endtask

  task automatic test_fetch_stall();
    fill_ideal();
    start_tab[0] = 1'b1;
    for (int c = 2; c < 5; c++) fv_tab[c] = 1'b0;
    run(36);
    for (int k = 0; k < 3; k++) check_done("fetch_stall_done", k, 5 + N * (3 + lat_of(k)));
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < MAXC; c++) begin
        start_tab[c] = (c == 0) || (c < 100 && $urandom_range(0, 9) == 0);
        fv_tab[c]    = (c >= 100) || ($urandom_range(0, 3) != 0);
        or_tab[c]    = (c >= 100) || ($urandom_range(0, 3) != 0);
      end
      run(150);
    end
  endtask

  task automatic test_reset_midop();
    fill_ideal();
    start_tab[0] = 1'b1;
    run(8);
    #2;
    tests++;
    if (obs[0][13] !== 1'b1) begin
      fails++;
      $display("FAIL midop_busy_before_reset got %b expected 1", obs[0][13]);
    end
    nrst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs[k] !== 14'd0) begin
        fails++;
        $display("FAIL midop_async_reset lat=%0d got %h expected 0", lat_of(k), obs[k]);
      end
    end
    release_reset();
    fill_ideal();
    start_tab[0] = 1'b1;
    run(34);
    for (int k = 0; k < 3; k++) check_done("after_reset_done", k, 2 + N * (3 + lat_of(k)));
  endtask

  task automatic test_back_to_back();
    int per, want;
    fill_ideal();
    for (int c = 0; c < 60; c++) start_tab[c] = 1'b1;
    run(95);
    for (int k = 0; k < 3; k++) begin
      per  = 3 + N * (3 + lat_of(k));
      want = (60 + per - 1) / per;
      tests++;
      if (done_cnt[k] !== want) begin
        fails++;
        $display("FAIL b2b_done_count lat=%0d got %0d expected %0d", lat_of(k), done_cnt[k], want);
      end
      tests++;
      if (clr_cnt[k] !== want) begin
        fails++;
        $display("FAIL b2b_clear_count lat=%0d got %0d expected %0d", lat_of(k), clr_cnt[k], want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_fetch_stall();
    test_random();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
